countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter, the counting-down counterpart of the team's free-running 4-bit up counter.
- Counts from a loaded value to zero and flags terminal count.
- Optionally auto-reloads to produce a periodic tick.
- Used as a programmable delay/interval generator beside the up counter in lab designs.

Parameters:
- WIDTH, 4, counter and load-value width in bits (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset: synchronous, active-low.
- load  input  1  capture load_val into count and reload registers, start running.
- load_val  input  WIDTH  start/reload value, sampled only when load=1.
- en  input  1  count enable; decrement occurs only in cycles with en=1.
- auto_reload  input  1  1 = restart from reload value at terminal count; 0 = stop at zero.
- out  output  WIDTH  current count, registered.
- running  output  1  high in RUN state.
- done  output  1  high in EXPIRED state.
- tc  output  1  one-cycle registered terminal-count pulse.

Behaviour:
- Reset (rst=0 at rising edge):
  - state=IDLE; out=0; reload register=0; running=0; done=0; tc=0.
  - Overrides load and en.
- States: IDLE, RUN, EXPIRED. Encoding is defined in the package.
- IDLE: out holds 0; en is ignored; load -> RUN.
- Load (any state, rst=1, load=1):
  - Next cycle: out=load_val, reload=load_val, state=RUN, tc=0.
  - load has priority over en in the same cycle; no decrement occurs that cycle.
- RUN, en=1, out!=0: out <= out-1.
- RUN, en=1, out==0:
  - tc=1 next cycle.
  - If auto_reload=1: out <= reload, stay in RUN.
  - If auto_reload=0: out stays 0, state <= EXPIRED.
- RUN, en=0: out, state and reload hold; tc=0.
- Terminal-count period: reload+1 enabled cycles from the load or the previous reload. Load of 0 gives a tc on every enabled cycle in auto-reload mode.
- EXPIRED:
  - out=0; done=1; en is ignored.
  - Leaves only via load or reset.
- tc:
  - Registered; high for exactly one cycle per terminal event.
  - Never high in IDLE or in the cycle right after a load.
- auto_reload is sampled combinationally only at the terminal event. Changing it mid-count has no other effect.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - Decrement never underflows because the zero case is handled explicitly.
  - Reload to all-ones is legal.
- running=(state==RUN); done=(state==EXPIRED). Both are decoded from registered state, glitch-free.
- Reset mid-count: next cycle is IDLE, out=0, and the reload value is lost.

Decomposition:
- Package countdown_pkg:
  - State typedef/localparams S_IDLE, S_RUN, S_EXPIRED.
  - Default WIDTH constant.
- No sub-module needed: one state register, count register and reload register in a single always block, plus output decode.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1, en=1 for 10 cycles, no load -> out=0, running=0, done=0, tc=0 throughout.
- One-shot: load_val=5, auto_reload=0, en=1 continuous:
  - out sequence 5,4,3,2,1,0.
  - tc high exactly one cycle, 6 cycles after the load cycle; done=1 from then on; out stays 0 for 20 more cycles.
- Auto-reload: load_val=3, auto_reload=1, en=1 for 20 cycles -> out 3,2,1,0,3,2,1,0,...; tc pulses every 4 cycles; done never asserts.
- Gated enable: load_val=4, en toggling 1,0,1,0... -> out decrements only on en=1 cycles; tc appears after 5 enabled cycles (10 clocks).
- Priority and wrap edges:
  - load asserted with en=1 while out=2 and load_val=15 -> out=15 next cycle, no tc.
  - load_val=0 with auto_reload=1 -> tc every enabled cycle and out stays 0.
- Reset mid-operation: load_val=9, count to 6, assert rst=0 one cycle -> out=0, state IDLE, tc=0; a subsequent load_val=2 counts 2,1,0 normally.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Counts a loaded value down to zero, then either stops (EXPIRED) or
// restarts from the captured reload value, giving a tc every reload+1
// enabled cycles.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] reload;
  logic             tc_q;

  // State, count and reload registers; load wins over enable, and the zero
  // case is handled before decrementing so the count never underflows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      reload <= '0;
      tc_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        cnt    <= load_val;
        reload <= load_val;
        state  <= S_RUN;
      end else begin
        case (state)
          S_RUN: begin
            if (en) begin
              if (cnt != '0) begin
                cnt <= cnt - ONE;
              end else begin
                tc_q <= 1'b1;
                if (auto_reload) begin
                  cnt <= reload;
                end else begin
                  state <= S_EXPIRED;
                end
              end
            end
          end
          S_EXPIRED: begin
            cnt <= '0;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Status outputs decoded straight from registered state.
  always_comb begin
    out     = cnt;
    tc      = tc_q;
    running = (state == S_RUN);
    done    = (state == S_EXPIRED);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] out;
  logic       running;
  logic       done;
  logic       tc;

  int unsigned nvec;
  int unsigned nerr;

  logic [3:0] gate_out [10];
  logic       gate_tc  [10];

  countdown_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .out         (out),
    .running     (running),
    .done        (done),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eo, input logic er,
                     input logic ed, input logic et);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {out, running, done, tc};
    exp = {eo, er, ed, et};
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got out=%0d run=%b done=%b tc=%b, expected out=%0d run=%b done=%b tc=%b",
             tag, out, running, done, tc, eo, er, ed, et);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    gate_out = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    gate_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; auto_reload = 1'b0;

    // Reset for two cycles, then idle with en high and no load.
    tick(); chk("reset0", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); chk("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("idle", 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // One-shot from 5.
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b1;
    tick(); load = 1'b0;
    chk("oneshot_load", 4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      tick(); chk("oneshot_cnt", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk("oneshot_tc", 4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(); chk("oneshot_hold", 4'd0, 1'b0, 1'b1, 1'b0);
    end

    // Auto-reload from 3: period of 4 enabled cycles.
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
    tick(); load = 1'b0;
    chk("auto_load", 4'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("auto_cnt", 4'(3 - (k % 4)), 1'b1, 1'b0, (k % 4) == 0);
    end

    // Gated enable: en = 0,1,0,1,... after loading 4.
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b0; en = 1'b1;
    tick(); load = 1'b0;
    chk("gate_load", 4'd4, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      en = (c % 2) == 1;
      tick();
      chk("gate_cnt", gate_out[c], !gate_tc[c], gate_tc[c], gate_tc[c]);
    end

    // Load beats enable, including a load to all-ones mid-count.
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
    tick(); load = 1'b0;
    tick(); chk("prio_pre", 4'd2, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd15;
    tick(); load = 1'b0;
    chk("prio_load", 4'd15, 1'b1, 1'b0, 1'b0);
    tick(); chk("prio_dec", 4'd14, 1'b1, 1'b0, 1'b0);

    // Load of 0 in auto-reload: tc on every enabled cycle.
    load = 1'b1; load_val = 4'd0; auto_reload = 1'b1; en = 1'b1;
    tick(); load = 1'b0;
    chk("zero_load", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("zero_tc", 4'd0, 1'b1, 1'b0, 1'b1);
    end
    en = 1'b0;
    tick(); chk("zero_hold", 4'd0, 1'b1, 1'b0, 1'b0);
    en = 1'b1; auto_reload = 1'b0;
    tick(); chk("zero_expire", 4'd0, 1'b0, 1'b1, 1'b1);

    // Reset mid-count, then a fresh load counts normally.
    load = 1'b1; load_val = 4'd9; auto_reload = 1'b0; en = 1'b1;
    tick(); load = 1'b0;
    tick(); tick(); tick();
    chk("mid_pre", 4'd6, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); chk("mid_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd2;
    tick(); load = 1'b0;
    chk("post_load", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk("post_1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk("post_0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); chk("post_tc", 4'd0, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
